// File: rtl/fetch_controller_pkg.sv
// Shared widths, fetch state encoding and prefetch entry layout for the fetch controller.
package fetch_controller_pkg;

  localparam int FC_ADDR_W  = 10;
  localparam int FC_INSTR_W = 16;
  localparam int FC_DEPTH   = 4;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FC_ADDR_W-1:0]  pc;
    logic [FC_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read combinationally from storage.
// Latency 1 cycle push-to-head; full accepts a push only together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_dat,
  output logic [WIDTH-1:0]         o_rd_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is cleared on reset so the head never reads as X while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wr_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns fetch PC and STOP/RUN state, queues {pc, instr} for decode.
// Latency 1 cycle fetch-to-output; decode backpressure stalls the PC once the queue fills.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                ADDR_W   = FC_ADDR_W,
  parameter int                INSTR_W  = FC_INSTR_W,
  parameter int                DEPTH    = FC_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [$clog2(DEPTH):0]      w_count;
  logic [ADDR_W+INSTR_W-1:0]   w_wr_dat;
  logic [ADDR_W+INSTR_W-1:0]   w_rd_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_STOP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: if (fetch_en)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!fetch_en) w_state_nxt = ST_STOP;
      default: w_state_nxt = ST_STOP;
    endcase
  end

  // A redirect voids any handshake in its cycle; a full queue still takes a push alongside a pop.
  assign w_pop  = out_valid & out_ready & ~redirect_valid;
  assign w_push = (r_state == ST_RUN) & ~redirect_valid & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_fetch_pc <= RESET_PC;
    else if (redirect_valid) r_fetch_pc <= redirect_pc;
    else if (w_push)         r_fetch_pc <= r_fetch_pc + ADDR_ONE;
  end

  assign w_wr_dat = {r_fetch_pc, imem_data};

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (redirect_valid),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wr_dat (w_wr_dat),
    .o_rd_dat (w_rd_dat),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign imem_addr = r_fetch_pc;
  assign out_valid = ~w_empty;
  assign {out_pc, out_instr} = w_rd_dat;
  assign busy      = (r_state == ST_RUN) | ~w_empty;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch from the 1024x16 combinational-read instruction memory. Holds the fetch PC and drives the memory address. Captures returned instructions with their PCs into a small prefetch FIFO, which decode drains with a valid/ready handshake. Redirects (jump, taken branch, JALR) flush the queue and restart fetch at a new PC.

Parameters:
ADDR_W, 10, instruction address width; memory depth is 2**ADDR_W
INSTR_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetch permitted; 0 = stop issuing new fetches
imem_addr  output  ADDR_W  address to instruction memory, equal to fetch_pc
imem_data  input  INSTR_W  instruction returned combinationally for imem_addr
redirect_valid  input  1  one-cycle pulse: flush queue and restart at redirect_pc
redirect_pc  input  ADDR_W  new fetch target
out_valid  output  1  FIFO head holds a valid instruction
out_ready  input  1  decode accepts the head this cycle
out_instr  output  INSTR_W  instruction at FIFO head
out_pc  output  ADDR_W  address of out_instr
busy  output  1  state is RUN or FIFO not empty

Behaviour:
- Reset values (async): state=STOP, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, out_valid=0. out_instr/out_pc are 0 with an empty queue; contents are don't-care when out_valid=0 but must not be X. busy=0.
- States:
  - STOP -> RUN when fetch_en=1.
  - RUN -> STOP when fetch_en=0.
  - Transition takes effect on the next edge. Fetch pushes occur only in RUN.
- push = (state==RUN) & !redirect_valid & (count<DEPTH | pop).
- pop = out_valid & out_ready & !redirect_valid.
- On push: write {fetch_pc, imem_data} at wr_ptr; fetch_pc <= fetch_pc+1, modulo 2**ADDR_W (1023 wraps to 0); wr_ptr wraps.
- On pop: rd_ptr advances. count updates by push-pop; simultaneous push and pop when full is legal and keeps count=DEPTH.
- out_valid = (count!=0), registered state only. out_instr/out_pc are read from the head entry. No combinational path from out_ready to out_valid.
- Latency: an instruction fetched in cycle N is visible at the output in cycle N+1. Steady state with out_ready=1 delivers one instruction per cycle.
- Redirect in cycle N:
  - count<=0, pointers reset.
  - fetch_pc<=redirect_pc.
  - No push or pop in cycle N; a handshake in cycle N is void and decode must discard it.
  - out_valid=0 in cycle N+1; first instruction from redirect_pc appears in cycle N+2 if RUN.
- Redirect in STOP: flush and fetch_pc update still apply; state remains STOP.
- fetch_en=0 in RUN: pushes stop from the next cycle; existing entries keep draining.
- reset asserted mid-operation: immediate return to reset values; reset dominates redirect.
- FIFO full with out_ready=0: fetch_pc holds and imem_addr stays stable.

Decomposition:
- Shared package: ADDR_W/INSTR_W constants, the STOP/RUN state encoding, and the FIFO entry struct {pc, instr}.
- One natural sub-module: fetch_fifo (parameterised synchronous FIFO with flush, push/pop, count, full/empty). The controller holds the PC and state machine.

Test Plan:
- Reset, fetch_en=1, out_ready=1; memory holds words 0..12 -> out_pc=0,1,2,... on consecutive cycles starting cycle 2 after reset release; out_instr matches memory.
- out_ready=0 for 10 cycles in RUN -> count saturates at 4; imem_addr holds at 4; releasing out_ready delivers pc 0..3 in order with no loss or duplicate.
- Redirect to 3 pulsed at cycle 5 with out_ready=1 -> out_valid=0 at cycle 6; out_pc=3 at cycle 7, then 4, 5.
- redirect_pc=1022 -> output sequence 1022, 1023, 0, 1 (wrap).
- fetch_en dropped while 3 entries queued -> those 3 drain; then out_valid=0, busy=0, imem_addr frozen.
- reset pulsed mid-stream with a full FIFO -> out_valid=0 immediately, fetch_pc=0; first instruction after release is pc 0.
